// File: rtl/des_pkg.sv
// Fixed FIPS 46-3 tables and shared types for the DES datapath.
// Table index 0 corresponds to FIPS output bit 1.
package des_pkg;
    localparam int KEY_W    = 64;
    localparam int CD_W     = 56;
    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;
    localparam int ROUNDS   = 16;

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    localparam int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // SHIFTS[n-1] = s[n]
    localparam int SHIFTS [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [HALF_W-1:0] rot28(input logic [HALF_W-1:0] x,
                                                input logic left, input logic two);
        logic [HALF_W-1:0] r;
        unique case ({left, two})
            2'b10:   r = {x[26:0], x[27]};
            2'b11:   r = {x[25:0], x[27:26]};
            2'b00:   r = {x[0], x[27:1]};
            default: r = {x[1:0], x[27:2]};
        endcase
        return r;
    endfunction
endpackage

// File: rtl/des_key_schedule_if.sv
// Request/subkey bundle between the key schedule and its consumer.
interface des_key_schedule_if;
    logic                          i_start;
    logic [des_pkg::KEY_W-1:0]     i_key;
    logic                          i_decrypt;
    logic                          i_ready;
    logic [des_pkg::SUBKEY_W-1:0]  o_subkey;
    logic                          o_valid;
    logic [3:0]                    o_round;
    logic                          o_busy;
    logic                          o_done;

    modport master (output i_start, i_key, i_decrypt, i_ready,
                    input  o_subkey, o_valid, o_round, o_busy, o_done);
    modport slave  (input  i_start, i_key, i_decrypt, i_ready,
                    output o_subkey, o_valid, o_round, o_busy, o_done);
endinterface

// File: rtl/des_pc2.sv
// PC-2 compression: pure wiring from the 56-bit C||D register to a 48-bit subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0]     cd_i,
    output logic [SUBKEY_W-1:0] subkey_o
);
    for (genvar g = 0; g < SUBKEY_W; g++) begin : g_bit
        assign subkey_o[SUBKEY_W-1-g] = cd_i[CD_W-PC2[g]];
    end

    // CD bits 9,18,22,25,35,38,43,54 are dropped by PC-2
    logic unused_cd;
    assign unused_cd = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                         cd_i[21], cd_i[18], cd_i[13], cd_i[2]};
endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one subkey per handshake, forward or reverse order.
module des_key_schedule
    import des_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    des_key_schedule_if.slave  bus
);
    state_e              state_q, state_d;
    logic [CD_W-1:0]     cd_q, cd_d, pc1_key;
    logic [3:0]          round_q, round_d;
    logic                dec_q, dec_d, done_q, done_d;
    logic                start_acc, hs, last;
    logic [3:0]          sh_idx;
    logic                sh_two;
    logic [SUBKEY_W-1:0] subkey;

    for (genvar g = 0; g < CD_W; g++) begin : g_pc1
        assign pc1_key[CD_W-1-g] = bus.i_key[KEY_W-PC1[g]];
    end

    logic unused_parity;
    assign unused_parity = ^{bus.i_key[56], bus.i_key[48], bus.i_key[40], bus.i_key[32],
                             bus.i_key[24], bus.i_key[16], bus.i_key[8],  bus.i_key[0]};

    assign start_acc = (state_q == ST_IDLE) && bus.i_start;
    assign hs        = (state_q == ST_RUN) && bus.i_ready;
    assign last      = hs && (round_q == 4'(ROUNDS-1));
    // Step j uses s[j+2] forward or s[16-j] in reverse
    assign sh_idx    = dec_q ? ~round_q : round_q + 4'd1;
    assign sh_two    = (SHIFTS[sh_idx] == 2);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_acc) state_d = ST_RUN;
            ST_RUN:  if (last)      state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_valid  = (state_q == ST_RUN);
        bus.o_busy   = (state_q == ST_RUN);
        bus.o_round  = round_q;
        bus.o_done   = done_q;
        bus.o_subkey = subkey;
    end

    // Decrypt loads C0D0 directly since the full rotation cycle returns to it
    always_comb begin
        cd_d    = cd_q;
        round_d = round_q;
        dec_d   = dec_q;
        done_d  = last;
        if (start_acc) begin
            dec_d   = bus.i_decrypt;
            round_d = '0;
            cd_d    = bus.i_decrypt ? pc1_key
                    : {rot28(pc1_key[CD_W-1:HALF_W], 1'b1, 1'b0),
                       rot28(pc1_key[HALF_W-1:0],    1'b1, 1'b0)};
        end else if (hs && !last) begin
            round_d = round_q + 4'd1;
            cd_d    = {rot28(cd_q[CD_W-1:HALF_W], !dec_q, sh_two),
                       rot28(cd_q[HALF_W-1:0],    !dec_q, sh_two)};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cd_q    <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cd_q    <= cd_d;
            round_q <= round_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    des_pc2 u_pc2 (
        .cd_i     (cd_q),
        .subkey_o (subkey)
    );
endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Iterative DES key-schedule generator. Loads a 64-bit key, applies PC-1, and produces the sixteen 48-bit round subkeys one per accepted handshake. Subkeys come out in forward order for encryption or reverse order for decryption. The block sits directly upstream of the round datapath's expansion/key-XOR stage, which drives the 6-bit inputs of the eight S-boxes (S_Box_1..S_Box_8).

## Interface
Parameters:
- None. All tables are fixed by FIPS 46-3.

Ports:
- i_clk  input  1  single clock; all state on rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_start  input  1  load request; accepted only when o_busy=0
- i_key  input  64  DES key; FIPS bit 1 = i_key[63]; parity bits (8,16,…,64) ignored
- i_decrypt  input  1  sampled with i_start; 1 = emit K16..K1, 0 = emit K1..K16
- i_ready  input  1  consumer accepts current subkey
- o_subkey  output  48  current subkey; FIPS bit 1 = o_subkey[47]
- o_valid  output  1  o_subkey holds a valid round key
- o_round  output  4  step index 0..15 (0 = first subkey emitted)
- o_busy  output  1  schedule in progress
- o_done  output  1  one-cycle pulse after the 16th handshake

## Operation
- State machine: IDLE, RUN.
- IDLE: o_valid=0, o_busy=0.
  - On i_start, load CD (56 bits: C=[55:28], D=[27:0]).
  - Encrypt: CD <= rotl28 of each half of PC1(i_key) by 1.
  - Decrypt: CD <= PC1(i_key) unrotated, because C16D16 = C0D0.
  - o_round <= 0, latch i_decrypt, go to RUN.
- RUN: o_valid=1, o_busy=1, o_subkey = PC2(CD). The PC-2 output is combinational from registers.
- Handshake (o_valid & i_ready) at step j = o_round:
  - Encrypt: rotate each half left by s[j+2], where s[n] = 1 for n ∈ {1,2,9,16} and 2 otherwise.
  - Decrypt: rotate each half right by s[16-j].
  - If j=15: go to IDLE, pulse o_done, leave CD unchanged. Otherwise o_round <= j+1.
- No handshake: CD, o_round and o_subkey hold stable. Backpressure of any length is allowed.
- i_start while o_busy=1 is ignored, including on the cycle of the final handshake.
- i_key and i_decrypt are sampled only on accepted start.
- Rotations are within each 28-bit half only. There is no carry between C and D.

## Timing
- Reset values, asynchronous on i_rst=1: state=IDLE, CD=0, o_round=0, o_valid=0, o_busy=0, o_done=0, latched decrypt=0.
- Reset asserted mid-schedule aborts immediately. No o_done is produced.
- Start latency: i_start high in cycle t (IDLE) gives o_valid=1 with the first subkey in cycle t+1.
- With i_ready held high, one subkey per cycle: steps at t+1..t+16, o_done=1 at t+17, o_valid=0 at t+17.
- Earliest restart: i_start in cycle t+17 (IDLE) gives the first subkey at t+18.
- o_done is high exactly one cycle and never coincides with o_valid.

## Structure
- Package des_pkg holds:
  - PC1 table (56 entries)
  - PC2 table (48 entries)
  - shift schedule s[1..16]
  - state enum
  - widths: KEY_W=64, CD_W=56, SUBKEY_W=48
- The S-box and permutation tables of later stages also belong in des_pkg.
- One natural sub-module: des_pc2 (combinational 56→48 select), reused by any unrolled key-schedule variant.
- PC-1 and the rotators stay inline.

## Test plan
- Encrypt, key 0x133457799BBCDFF1, i_ready=1 → step 0 0x1B02EFFC7072, step 1 0x79AED9DBC9E5, step 15 0xCB3D8B0E17F5, o_done at start+17.
- Decrypt, same key → step 0 0xCB3D8B0E17F5, step 15 0x1B02EFFC7072. The full sequence equals the encrypt sequence reversed.
- Random i_ready (30% duty), encrypt → o_subkey and o_round stable while i_ready=0; the accepted sequence matches the no-stall run; exactly 16 handshakes.
- i_start pulsed with a different key at steps 5 and 15 → ignored; the schedule completes with the original key; the new start is accepted only once o_busy=0.
- i_rst asserted at step 7 → all outputs 0 in the same cycle (asynchronous); a subsequent start yields the correct step 0.
- Key 0x133457799BBCDFF1 vs 0x123456789ABCDEF0-style parity-flipped variant (bits 8,16,…,64 toggled) → identical subkeys.
